adc_capture_player: RTL and testbench
=====================================

// Module: adc_capture_player
// PURPOSE
//  Parametrised ADC snapshot-and-replay engine. A debounced key press captures
//  DEPTH consecutive ADC samples into on-chip RAM at a programmable sample rate.
//  The buffer is then replayed, width-converted, to the DAC bus with strobes.
//  Sits between the ADC input pins and the DAC pins (DataA/ClkA/WRTA) in top.
// PARAMETERS
//  ADC_W    12    ADC sample width, offset binary
//  DAC_W    14    DAC word width, offset binary; must be >= ADC_W
//  ADDR_W   13    buffer address width; DEPTH = 2**ADDR_W samples
//  SMP_DIV  4     clk cycles per sample strobe (>=2)
//  DEB_CYC  65000 clk cycles key must be stable before accepted
// PORTS
//  clk           in   1       system clock; all logic on rising edge
//  rst           in   1       asynchronous, active-high reset
//  adc_data      in   ADC_W   ADC sample, sampled on strobe cycle
//  key           in   1       raw pushbutton, asynchronous, active-high
//  mode          in   1       0 = loop replay forever, 1 = one-shot replay
//  dac_data      out  DAC_W   DAC word (registered)
//  dac_clk       out  1       DAC clock strobe
//  dac_wrt       out  1       DAC write strobe
//  busy          out  1       high in CAPTURE or PLAY
//  capture_done  out  1       1-clk pulse when last capture sample written
// BEHAVIOUR
//  Reset: state IDLE; dac_data = 1<<(DAC_W-1) (midscale); dac_clk, dac_wrt,
//   busy, capture_done = 0; addresses, divider, debounce = 0.
//  Key: 2-FF sync, then debounce counter; level accepted after DEB_CYC stable
//   cycles; rising edge of accepted level -> 1-clk key_pulse. Shorter glitches ignored.
//  Strobe: divider counts 0..SMP_DIV-1, strb when count == SMP_DIV-1; divider
//   cleared to 0 on every accepted key_pulse.
//  FSM: IDLE -key_pulse-> CAPTURE (wr_addr=0).
//   CAPTURE: on strb write adc_data to mem[wr_addr], wr_addr++; write at
//    wr_addr == DEPTH-1 -> capture_done pulse (same cycle as write), -> PLAY,
//    rd_addr=0. key_pulse in CAPTURE ignored.
//   PLAY: on strb read mem[rd_addr]; rd_addr wraps DEPTH-1 -> 0. mode=1: read
//    of DEPTH-1 -> IDLE after that sample is output. key_pulse in PLAY ->
//    CAPTURE (replay stops immediately, dac_data holds last word).
//   mode sampled at each wrap decision, changing it mid-replay is legal.
//  Replay pipeline: strb at cycle t -> RAM sync read t+1 -> dac_data update
//   t+2 -> dac_wrt and dac_clk high for exactly 1 clk at t+3. No strobe
//   in IDLE/CAPTURE.
//  Width: dac_data = {sample, (DAC_W-ADC_W) zeros}; no sign change, no rounding.
//  Entering IDLE from PLAY: dac_data returns to midscale on t+2 of last sample's
//   pipeline completion; busy drops the same cycle.
//  Async rst at any time: all outputs to reset value immediately; RAM contents
//   undefined afterwards (not cleared).
// STRUCTURE
//  Package adc_cap_pkg: state enum {IDLE, CAPTURE, PLAY}; midscale function.
//  Sub-module key_debounce (sync + DEB_CYC counter + edge pulse), instanced once.
//  Buffer as inferred single-port-write/sync-read RAM in this module.
// TESTING (ADC_W=12, DAC_W=14, ADDR_W=4, SMP_DIV=4, DEB_CYC=8)
//  1 rst asserted -> dac_data=14'h2000, dac_wrt=0, busy=0; held through release.
//  2 key high 3 clks then low -> no capture. key high 20 clks -> busy=1;
//    adc ramp 0..15 per strb -> capture_done after 16th strobe.
//  3 mode=0 after 2 -> dac_data 0,4,8,...,60,0,4... one dac_wrt every 4 clks,
//    dac_wrt exactly 3 clks after each strb.
//  4 mode=1 -> 16 words 0..60 output once, then IDLE, busy=0, dac_data=14'h2000.
//  5 key press during CAPTURE -> ignored, capture_done at same time as no-key run;
//    key press in PLAY -> new capture of ramp 100..115, replay 400..460.
//  6 rst pulse mid-PLAY -> outputs reset asynchronously, no further dac_wrt.

Source files
------------

// File: rtl/adc_cap_pkg.sv
// rtl/adc_cap_pkg.sv - shared types and helpers for the ADC capture/replay engine
package adc_cap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_PLAY    = 2'd2
    } state_t;

    // Offset-binary zero for a converter word of the given width.
    function automatic logic [31:0] midscale(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - pushbutton synchroniser, debouncer and press pulse
module key_debounce #(
    parameter int DEB_CYC = 65000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_pulse
);

    localparam int              CNT_W    = $clog2(DEB_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_pulse;
    logic [CNT_W-1:0] r_cnt;

    // Two-flop synchroniser for the asynchronous key input.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it differs from the current one for
    // DEB_CYC consecutive cycles; any bounce back restarts the count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_pulse <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/adc_capture_player.sv
// rtl/adc_capture_player.sv - key-triggered ADC snapshot buffer with DAC replay
module adc_capture_player
    import adc_cap_pkg::*;
#(
    parameter int ADC_W   = 12,
    parameter int DAC_W   = 14,
    parameter int ADDR_W  = 13,
    parameter int SMP_DIV = 4,
    parameter int DEB_CYC = 65000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [ADC_W-1:0] i_adc_data,
    input  logic             i_key,
    input  logic             i_mode,
    output logic [DAC_W-1:0] o_dac_data,
    output logic             o_dac_clk,
    output logic             o_dac_wrt,
    output logic             o_busy,
    output logic             o_capture_done
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam int                PAD_W     = DAC_W - ADC_W;
    localparam int                DIV_W     = (SMP_DIV > 2) ? $clog2(SMP_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SMP_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [DAC_W-1:0]  MIDSCALE  = DAC_W'(midscale(DAC_W));

    state_t            r_state;
    logic [DIV_W-1:0]  r_div;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_busy;
    logic              r_capture_done;

    logic [ADC_W-1:0]  r_mem [DEPTH];
    logic [ADC_W-1:0]  r_rd_data;

    logic              r_rd_vld;
    logic              r_rd_last;
    logic              r_dac_vld;
    logic              r_dac_last;
    logic              r_wrt;
    logic              r_wrt_last;
    logic [DAC_W-1:0]  r_dac_data;

    logic              w_key_pulse;
    logic              w_key_accept;
    logic              w_strb;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_rd_last;
    logic              w_draining;
    logic              w_cancel;
    logic              w_play_end;

    key_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_key_debounce (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_key   (i_key),
        .o_pulse (w_key_pulse)
    );

    // A press during CAPTURE is ignored entirely, including for strobe
    // phase, so the capture timeline is unaffected by stray presses.
    assign w_key_accept = w_key_pulse && (r_state != ST_CAPTURE);
    assign w_strb       = (r_div == DIV_LAST);
    assign w_wr_en      = w_strb && (r_state == ST_CAPTURE);
    // Once the final one-shot sample is in flight, no further reads start
    // (matters when SMP_DIV is short enough to strobe again mid-pipeline).
    assign w_draining   = r_rd_last || r_dac_last || r_wrt_last;
    assign w_rd_en      = w_strb && (r_state == ST_PLAY) && !w_key_pulse && !w_draining;
    // mode is looked at only when the read pointer is about to wrap.
    assign w_rd_last    = (r_rd_addr == ADDR_LAST) && i_mode;
    assign w_cancel     = w_key_pulse && (r_state == ST_PLAY);
    assign w_play_end   = r_wrt && r_wrt_last;

    // Sample-rate divider, re-phased by each accepted key press.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div <= '0;
        end else if (w_key_accept || (r_div == DIV_LAST)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Control FSM: IDLE -> CAPTURE -> PLAY, with address counters and status.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_wr_addr      <= '0;
            r_rd_addr      <= '0;
            r_busy         <= 1'b0;
            r_capture_done <= 1'b0;
        end else begin
            r_capture_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_key_pulse) begin
                        r_state   <= ST_CAPTURE;
                        r_wr_addr <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (w_wr_en) begin
                        r_wr_addr <= r_wr_addr + 1'b1;
                        if (r_wr_addr == ADDR_LAST) begin
                            r_capture_done <= 1'b1;
                            r_state        <= ST_PLAY;
                            r_rd_addr      <= '0;
                        end
                    end
                end
                ST_PLAY: begin
                    if (w_key_pulse) begin
                        r_state   <= ST_CAPTURE;
                        r_wr_addr <= '0;
                    end else begin
                        if (w_rd_en) begin
                            r_rd_addr <= r_rd_addr + 1'b1;
                        end
                        if (w_play_end) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sample buffer: registered write port, synchronous read port, no reset
    // so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_addr] <= i_adc_data;
        end
        if (w_rd_en) begin
            r_rd_data <= r_mem[r_rd_addr];
        end
    end

    // Replay pipeline: RAM data -> DAC word -> one-cycle write/clock strobe.
    // A key press in PLAY flushes in-flight words so the DAC holds its last.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_vld   <= 1'b0;
            r_rd_last  <= 1'b0;
            r_dac_vld  <= 1'b0;
            r_dac_last <= 1'b0;
            r_wrt      <= 1'b0;
            r_wrt_last <= 1'b0;
            r_dac_data <= MIDSCALE;
        end else begin
            r_rd_vld   <= w_rd_en;
            r_rd_last  <= w_rd_en && w_rd_last;
            r_dac_vld  <= r_rd_vld && !w_cancel;
            r_dac_last <= r_rd_last && !w_cancel;
            r_wrt      <= r_dac_vld && !w_cancel;
            r_wrt_last <= r_dac_last && !w_cancel;
            if (r_rd_vld && !w_cancel) begin
                r_dac_data <= DAC_W'(r_rd_data) << PAD_W;
            end else if (w_play_end && !w_cancel) begin
                r_dac_data <= MIDSCALE;
            end
        end
    end

    assign o_dac_data     = r_dac_data;
    assign o_dac_clk      = r_wrt;
    assign o_dac_wrt      = r_wrt;
    assign o_busy         = r_busy;
    assign o_capture_done = r_capture_done;

endmodule

// File: tb/tb_adc_capture_player.sv
// tb/tb_adc_capture_player.sv - self-checking bench for adc_capture_player
module tb_adc_capture_player;

    localparam int ADC_W    = 12;
    localparam int DAC_W    = 14;
    localparam int ADDR_W   = 4;
    localparam int SMP_DIV  = 4;
    localparam int DEB_CYC  = 8;
    localparam int DEPTH    = 16;
    // Key driven high in cycle c: two synchroniser stages, DEB_CYC stable
    // cycles, press pulse, then the FSM is in CAPTURE (busy=1) at c+KEY_LAT.
    localparam int KEY_LAT  = DEB_CYC + 3;
    localparam int KEY_HOLD = 20;
    localparam int NCYC     = 700;
    localparam int RUN_END  = 600;
    localparam logic [DAC_W-1:0] MID = 14'h2000;

    logic             clk;
    logic             rst;
    logic [ADC_W-1:0] adc;
    logic             key;
    logic             mode;
    logic [DAC_W-1:0] dac_data;
    logic             dac_clk;
    logic             dac_wrt;
    logic             busy;
    logic             capture_done;

    adc_capture_player #(
        .ADC_W   (ADC_W),
        .DAC_W   (DAC_W),
        .ADDR_W  (ADDR_W),
        .SMP_DIV (SMP_DIV),
        .DEB_CYC (DEB_CYC)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_adc_data     (adc),
        .i_key          (key),
        .i_mode         (mode),
        .o_dac_data     (dac_data),
        .o_dac_clk      (dac_clk),
        .o_dac_wrt      (dac_wrt),
        .o_busy         (busy),
        .o_capture_done (capture_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;
    int cyc;

    // Stimulus per cycle and expected outputs per cycle.
    logic [ADC_W-1:0] drv_adc [NCYC];
    bit               drv_key [NCYC];
    bit               drv_mode[NCYC];
    logic [DAC_W-1:0] e_dac   [NCYC];
    bit               e_wrt   [NCYC];
    bit               e_busy  [NCYC];
    bit               e_done  [NCYC];
    logic [ADC_W-1:0] buf_m   [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_dac_from(input int u, input logic [DAC_W-1:0] w);
        for (int c = u; c < NCYC; c++) e_dac[c] = w;
    endtask

    task automatic set_busy_from(input int u, input bit v);
        for (int c = u; c < NCYC; c++) e_busy[c] = v;
    endtask

    task automatic press_key(input int c0);
        for (int c = c0; c < c0 + KEY_HOLD; c++) drv_key[c] = 1'b1;
    endtask

    // Capture starting with busy first high in cycle b: the k-th strobe
    // falls on b+SMP_DIV-1+SMP_DIV*k, so each sample is held for a window.
    task automatic plan_capture(input int b, input bit ramp, input int base);
        for (int k = 0; k < DEPTH; k++) begin
            buf_m[k] = ramp ? 12'(base + k) : 12'($urandom);
            for (int i = 0; i < SMP_DIV; i++) drv_adc[b + SMP_DIV * k + i] = buf_m[k];
        end
        set_busy_from(b, 1'b1);
        e_done[b + SMP_DIV * DEPTH] = 1'b1;
    endtask

    // Replay following capture b: word j strobed at s, DAC word at s+2,
    // write strobe at s+3. passes>0: one-shot after that many passes.
    task automatic plan_play(input int b, input int passes);
        for (int j = 0; j < 1000; j++) begin
            int s;
            s = b + SMP_DIV - 1 + SMP_DIV * (DEPTH + j);
            if (s + SMP_DIV >= NCYC) break;
            set_dac_from(s + 2, {buf_m[j % DEPTH], 2'b00});
            e_wrt[s + 3] = 1'b1;
            if (passes > 0 && j == DEPTH * passes - 1) begin
                set_dac_from(s + 4, MID);
                set_busy_from(s + 4, 1'b0);
                break;
            end
        end
    endtask

    // Press pulse in PLAY at cycle p: nothing more is written after p.
    task automatic cut_play(input int p);
        for (int c = p + 1; c < NCYC; c++) e_wrt[c] = 1'b0;
        set_dac_from(p + 1, e_dac[p]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        adc  = drv_adc[cyc];
        key  = drv_key[cyc];
        mode = drv_mode[cyc];
    endtask

    task automatic check_plan();
        chk("dac_data", 32'(dac_data), 32'(e_dac[cyc]));
        chk("dac_wrt", 32'(dac_wrt), 32'(e_wrt[cyc]));
        chk("dac_clk", 32'(dac_clk), 32'(e_wrt[cyc]));
        chk("busy", 32'(busy), 32'(e_busy[cyc]));
        chk("capture_done", 32'(capture_done), 32'(e_done[cyc]));
    endtask

    initial begin
        int b1;
        int b2;
        int b3;
        int kp;
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        rst   = 1'b1;
        key   = 1'b0;
        mode  = 1'b0;
        adc   = '0;
        for (int c = 0; c < NCYC; c++) begin
            drv_adc[c]  = 12'($urandom);
            drv_key[c]  = 1'b0;
            drv_mode[c] = 1'b0;
            e_dac[c]    = MID;
            e_wrt[c]    = 1'b0;
            e_busy[c]   = 1'b0;
            e_done[c]   = 1'b0;
        end

        // Short glitch: never accepted.
        for (int c = 10; c < 13; c++) drv_key[c] = 1'b1;

        // Ramp capture, loop one pass, switch to one-shot during second pass.
        press_key(40);
        b1 = 40 + KEY_LAT;
        plan_capture(b1, 1'b1, 0);
        plan_play(b1, 2);
        for (int c = b1 + 150; c < 260; c++) drv_mode[c] = 1'b1;

        // Random capture with a stray press while capturing, loop replay.
        press_key(270);
        b2 = 270 + KEY_LAT;
        plan_capture(b2, 1'b0, 0);
        press_key(300);
        plan_play(b2, 0);

        // Press during replay at a random strobe phase: new ramp capture.
        kp = 420 + int'($urandom_range(0, SMP_DIV - 1));
        press_key(kp);
        b3 = kp + KEY_LAT;
        cut_play(b3 - 1);
        plan_capture(b3, 1'b1, 100);
        plan_play(b3, 0);

        while (cyc < RUN_END) begin
            tick();
            if (cyc == 4) rst = 1'b0;
            check_plan();
        end

        // Asynchronous reset in the middle of replay.
        #3;
        rst = 1'b1;
        #1;
        chk("rst_async_dac_data", 32'(dac_data), 32'(MID));
        chk("rst_async_dac_wrt", 32'(dac_wrt), 32'd0);
        chk("rst_async_dac_clk", 32'(dac_clk), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        chk("rst_async_capture_done", 32'(capture_done), 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            key = 1'b0;
            if (i == 2) rst = 1'b0;
            chk("post_rst_dac_wrt", 32'(dac_wrt), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
            chk("post_rst_dac_data", 32'(dac_data), 32'(MID));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
